nx1_prn: RTL and testbench

- Centronics-style printer port back end, directly downstream of the X1 8255 PIA.
- Consumes the PIA port A output as data and one port C output bit as strobe.
- Returns BUSY to a PIA port B input bit.
- Buffers captured bytes in a small FIFO and presents them to the host/SD logging side on a valid/ready stream.

---
 rtl/nx1_prn.sv | 135 +++++++++++++
 tb/tb_nx1_prn.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx1_prn.sv
// Centronics printer port back end: synchronizes the PIA strobe, captures the
// data byte into a first-word-fall-through FIFO and drives the BUSY/ACK handshake.
module nx1_prn #(
   parameter int FIFO_AW    = 3,
   parameter int BUSY_HOLD  = 4,
   parameter int ACK_CYCLES = 16
) (
   input  logic               I_CLK,
   input  logic               I_RESET,
   input  logic [7:0]         I_PD,
   input  logic               I_STB_N,
   output logic               O_BUSY,
   output logic               O_ACK_N,
   output logic [7:0]         O_Q_DATA,
   output logic               O_Q_VALID,
   input  logic               I_Q_READY,
   output logic [FIFO_AW:0]   O_LEVEL,
   output logic [1:0]         O_ERR,
   input  logic               I_ERR_CLR
);

   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [1:0] {IDLE, HOLD, ACK} state_t;

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               s1_q, s2_q, s3_q;
   logic [1:0]         fill_q;
   logic               armed_q, armed_d;
   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wptr_q, rptr_q;
   logic [FIFO_AW:0]   level_q;
   logic [7:0]         last_q;
   logic [1:0]         err_q, err_d;
   logic [1:0]         errSet;
   logic               fall, full, pop, push;

   assign fall = s3_q & ~s2_q & armed_q;
   assign full = (level_q == (FIFO_AW+1)'(DEPTH));
   assign pop  = (level_q != '0) & I_Q_READY;

   // The synchronizer presets to ones on reset; fill_q marks when s2 holds a
   // genuinely sampled strobe, so a strobe held low across reset never arms.
   assign armed_d = armed_q | (fill_q[1] & s2_q);

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         s3_q    <= 1'b1;
         fill_q  <= 2'b00;
         armed_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         err_q   <= 2'b00;
      end else begin
         s1_q    <= I_STB_N;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         fill_q  <= {fill_q[0], 1'b1};
         armed_q <= armed_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      errSet  = 2'b00;
      O_BUSY  = 1'b0;
      O_ACK_N = 1'b1;
      unique case (state_q)
         IDLE: begin
            O_BUSY = full;
            if (fall) begin
               if (!full || pop) push = 1'b1;
               else              errSet[0] = 1'b1;
               state_d = HOLD;
               cnt_d   = 8'(BUSY_HOLD - 1);
            end
         end
         HOLD: begin
            O_BUSY = 1'b1;
            if (fall) errSet[1] = 1'b1;
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (s2_q) begin
               state_d = ACK;
               cnt_d   = 8'(ACK_CYCLES - 1);
            end
         end
         ACK: begin
            O_BUSY  = 1'b1;
            O_ACK_N = 1'b0;
            if (fall) errSet[1] = 1'b1;
            if (cnt_q == 8'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase
      err_d = (err_q & ~{2{I_ERR_CLR}}) | errSet;
   end

   always_ff @(posedge I_CLK) begin
      if (push) mem_q[wptr_q] <= I_PD;
   end

   // last_q keeps the most recently popped byte visible once the FIFO drains.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         last_q  <= 8'h00;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
            last_q <= mem_q[rptr_q];
         end
         if (push && !pop)      level_q <= level_q + 1'b1;
         else if (pop && !push) level_q <= level_q - 1'b1;
      end
   end

   assign O_Q_VALID = (level_q != '0);
   assign O_Q_DATA  = O_Q_VALID ? mem_q[rptr_q] : last_q;
   assign O_LEVEL   = level_q;
   assign O_ERR     = err_q;

endmodule

// File: tb/tb_nx1_prn.sv
// Randomized bench for nx1_prn against a queue-based model of the printer
// port: bytes, error flags and handshake timing derived from the port rules.
module tb_nx1_prn;

   localparam int DEPTH      = 8;
   localparam int BUSY_HOLD  = 4;
   localparam int ACK_CYCLES = 16;

   logic       I_CLK = 1'b0;
   logic       I_RESET = 1'b1;
   logic [7:0] I_PD = 8'h00;
   logic       I_STB_N = 1'b1;
   logic       O_BUSY, O_ACK_N, O_Q_VALID;
   logic [7:0] O_Q_DATA;
   logic       I_Q_READY = 1'b0;
   logic [3:0] O_LEVEL;
   logic [1:0] O_ERR;
   logic       I_ERR_CLR = 1'b0;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] q[$];
   logic [7:0] lastData = 8'h00;
   logic [1:0] expErr = 2'b00;
   bit         randReady = 1'b0;

   nx1_prn #(.FIFO_AW(3), .BUSY_HOLD(BUSY_HOLD), .ACK_CYCLES(ACK_CYCLES)) dut (
      .I_CLK(I_CLK), .I_RESET(I_RESET), .I_PD(I_PD), .I_STB_N(I_STB_N),
      .O_BUSY(O_BUSY), .O_ACK_N(O_ACK_N), .O_Q_DATA(O_Q_DATA),
      .O_Q_VALID(O_Q_VALID), .I_Q_READY(I_Q_READY), .O_LEVEL(O_LEVEL),
      .O_ERR(O_ERR), .I_ERR_CLR(I_ERR_CLR)
   );

   always #5 I_CLK = ~I_CLK;

   // One clock with the model advanced; kind 1 = fall seen in IDLE, 2 = fall while busy.
   task automatic tick(input int kind);
      logic       pop, push, clr;
      logic [1:0] set;
      logic [7:0] pd;
      if (randReady) I_Q_READY = 1'($urandom_range(0, 1));
      pop  = I_Q_READY && (q.size() > 0);
      push = 1'b0;
      set  = 2'b00;
      pd   = I_PD;
      clr  = I_ERR_CLR;
      if (kind == 1) begin
         if (q.size() < DEPTH || pop) push = 1'b1;
         else                         set[0] = 1'b1;
      end else if (kind == 2) begin
         set[1] = 1'b1;
      end
      @(posedge I_CLK);
      if (pop) begin
         lastData = q[0];
         void'(q.pop_front());
      end
      if (push) q.push_back(pd);
      expErr = (expErr & ~{2{clr}}) | set;
      #1;
   endtask

   task automatic applyReset();
      I_RESET = 1'b1;
      I_Q_READY = 1'b0;
      I_ERR_CLR = 1'b0;
      randReady = 1'b0;
      repeat (2) @(posedge I_CLK);
      #1;
      I_RESET = 1'b0;
      q.delete();
      lastData = 8'h00;
      expErr = 2'b00;
      repeat (4) tick(0);
   endtask

   task automatic strobe(input logic [7:0] d, input int lowCycles, input int kind,
                         input bit clrAtCap, input bit readyAtCap);
      int n;
      n = (lowCycles > 3) ? lowCycles : 3;
      I_PD = d;
      I_STB_N = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == lowCycles) I_STB_N = 1'b1;
         if (i == 2) begin
            if (clrAtCap) I_ERR_CLR = 1'b1;
            if (readyAtCap) I_Q_READY = 1'b1;
         end
         tick((i == 2) ? kind : 0);
         if (i == 2) begin
            I_ERR_CLR = 1'b0;
            if (readyAtCap) I_Q_READY = 1'b0;
         end
      end
      I_STB_N = 1'b1;
   endtask

   task automatic waitHandshake(output int preAck, output int ackLow, output bit ok);
      preAck = 0;
      ackLow = 0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick(0);
         if (!O_ACK_N) ackLow++;
         else if (ackLow > 0) begin
            ok = 1'b1;
            break;
         end else if (O_BUSY) preAck++;
      end
   endtask

   task automatic waitAckLow(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!O_ACK_N) begin
            ok = 1'b1;
            break;
         end
         tick(0);
      end
   endtask

   task automatic test_reset();
      applyReset();
      vectors++; if (O_LEVEL !== 4'd0) begin miscompares++; $display("[TB] FAIL rst_level got %0d want 0", O_LEVEL); end
      vectors++; if (O_Q_VALID !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid got %b want 0", O_Q_VALID); end
      vectors++; if (O_Q_DATA !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_data got %h want 00", O_Q_DATA); end
      vectors++; if (O_BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy got %b want 0", O_BUSY); end
      vectors++; if (O_ACK_N !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_ackn got %b want 1", O_ACK_N); end
      vectors++; if (O_ERR !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_err got %b want 00", O_ERR); end
   endtask

   task automatic test_single_capture();
      int pre, ackLow;
      bit ok;
      applyReset();
      I_PD = 8'h41;
      I_STB_N = 1'b0;
      tick(0);
      tick(0);
      vectors++; if (O_LEVEL !== 4'd0) begin miscompares++; $display("[TB] FAIL cap_early_level got %0d want 0", O_LEVEL); end
      vectors++; if (O_BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL cap_early_busy got %b want 0", O_BUSY); end
      tick(1);
      vectors++; if (O_BUSY !== 1'b1) begin miscompares++; $display("[TB] FAIL cap_busy got %b want 1", O_BUSY); end
      vectors++; if (O_Q_VALID !== 1'b1) begin miscompares++; $display("[TB] FAIL cap_valid got %b want 1", O_Q_VALID); end
      vectors++; if (O_LEVEL !== 4'(q.size())) begin miscompares++; $display("[TB] FAIL cap_level got %0d want %0d", O_LEVEL, q.size()); end
      tick(0);
      tick(0);
      I_STB_N = 1'b1;
      waitHandshake(pre, ackLow, ok);
      vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL cap_handshake got timeout want ack pulse"); end
      vectors++; if (pre + 3 < BUSY_HOLD) begin miscompares++; $display("[TB] FAIL cap_busy_hold got %0d want >=%0d", pre + 3, BUSY_HOLD); end
      vectors++; if (ackLow != ACK_CYCLES) begin miscompares++; $display("[TB] FAIL cap_ack_width got %0d want %0d", ackLow, ACK_CYCLES); end
      vectors++; if (O_BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL cap_busy_after got %b want 0", O_BUSY); end
      vectors++; if (O_Q_DATA !== 8'h41) begin miscompares++; $display("[TB] FAIL cap_data got %h want 41", O_Q_DATA); end
   endtask

   task automatic test_overflow_drain();
      int pre, ackLow;
      bit ok;
      applyReset();
      for (int i = 0; i < DEPTH; i++) begin
         strobe(8'(i), 2, 1, 1'b0, 1'b0);
         waitHandshake(pre, ackLow, ok);
         vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL fill_handshake got timeout want ack pulse"); end
      end
      vectors++; if (O_LEVEL !== 4'd8) begin miscompares++; $display("[TB] FAIL fill_level got %0d want 8", O_LEVEL); end
      vectors++; if (O_BUSY !== 1'b1) begin miscompares++; $display("[TB] FAIL full_busy got %b want 1", O_BUSY); end
      strobe(8'hFF, 2, 1, 1'b0, 1'b0);
      waitHandshake(pre, ackLow, ok);
      vectors++; if (O_ERR !== expErr || expErr !== 2'b01) begin miscompares++; $display("[TB] FAIL ovf_err got %b want %b", O_ERR, 2'b01); end
      vectors++; if (O_LEVEL !== 4'd8) begin miscompares++; $display("[TB] FAIL ovf_level got %0d want 8", O_LEVEL); end
      I_Q_READY = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         vectors++; if (O_Q_DATA !== q[0] || O_Q_VALID !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_data got %h/%b want %h/1", O_Q_DATA, O_Q_VALID, q[0]); end
         tick(0);
         if (i == 0) begin
            vectors++; if (O_BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_busy got %b want 0", O_BUSY); end
         end
      end
      I_Q_READY = 1'b0;
      vectors++; if (O_Q_VALID !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_empty got %b want 0", O_Q_VALID); end
      vectors++; if (O_Q_DATA !== 8'h07) begin miscompares++; $display("[TB] FAIL drain_hold got %h want 07", O_Q_DATA); end
   endtask

   task automatic test_busy_error();
      int pre, ackLow;
      bit ok;
      applyReset();
      strobe(8'h55, 1, 1, 1'b0, 1'b0);
      waitAckLow(ok);
      vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL berr_ack got timeout want ack low"); end
      strobe(8'hAA, 1, 2, 1'b0, 1'b0);
      waitHandshake(pre, ackLow, ok);
      vectors++; if (O_LEVEL !== 4'(q.size()) || q.size() != 1) begin miscompares++; $display("[TB] FAIL berr_level got %0d want 1", O_LEVEL); end
      vectors++; if (O_ERR !== 2'b10) begin miscompares++; $display("[TB] FAIL berr_err got %b want 10", O_ERR); end
      I_ERR_CLR = 1'b1;
      tick(0);
      I_ERR_CLR = 1'b0;
      vectors++; if (O_ERR !== 2'b00) begin miscompares++; $display("[TB] FAIL errclr got %b want 00", O_ERR); end
      strobe(8'h33, 1, 1, 1'b0, 1'b0);
      waitAckLow(ok);
      strobe(8'hCC, 1, 2, 1'b1, 1'b0);
      waitHandshake(pre, ackLow, ok);
      vectors++; if (O_ERR !== 2'b10) begin miscompares++; $display("[TB] FAIL errclr_prio got %b want 10", O_ERR); end
   endtask

   task automatic test_full_push_pop();
      int pre, ackLow;
      bit ok;
      applyReset();
      for (int i = 0; i < DEPTH; i++) begin
         strobe(8'h10 + 8'(i), 1, 1, 1'b0, 1'b0);
         waitHandshake(pre, ackLow, ok);
      end
      strobe(8'hEE, 1, 1, 1'b0, 1'b1);
      waitHandshake(pre, ackLow, ok);
      vectors++; if (O_LEVEL !== 4'd8) begin miscompares++; $display("[TB] FAIL pp_level got %0d want 8", O_LEVEL); end
      vectors++; if (O_ERR !== 2'b00) begin miscompares++; $display("[TB] FAIL pp_err got %b want 00", O_ERR); end
      vectors++; if (O_Q_DATA !== 8'h11) begin miscompares++; $display("[TB] FAIL pp_head got %h want 11", O_Q_DATA); end
      I_Q_READY = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         vectors++; if (O_Q_DATA !== q[0]) begin miscompares++; $display("[TB] FAIL pp_order got %h want %h", O_Q_DATA, q[0]); end
         tick(0);
      end
      I_Q_READY = 1'b0;
      vectors++; if (O_Q_DATA !== 8'hEE || O_Q_VALID !== 1'b0) begin miscompares++; $display("[TB] FAIL pp_last got %h/%b want EE/0", O_Q_DATA, O_Q_VALID); end
   endtask

   task automatic test_held_low_reset();
      int pre, ackLow;
      bit ok;
      I_STB_N = 1'b0;
      applyReset();
      repeat (10) tick(0);
      vectors++; if (O_LEVEL !== 4'd0 || O_Q_VALID !== 1'b0) begin miscompares++; $display("[TB] FAIL held_level got %0d/%b want 0/0", O_LEVEL, O_Q_VALID); end
      vectors++; if (O_BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL held_busy got %b want 0", O_BUSY); end
      I_STB_N = 1'b1;
      repeat (4) tick(0);
      strobe(8'h77, 1, 1, 1'b0, 1'b0);
      vectors++; if (O_LEVEL !== 4'd1 || O_Q_DATA !== 8'h77) begin miscompares++; $display("[TB] FAIL held_release got %0d/%h want 1/77", O_LEVEL, O_Q_DATA); end
      waitHandshake(pre, ackLow, ok);
   endtask

   task automatic test_reset_in_ack();
      bit ok;
      applyReset();
      strobe(8'h5A, 1, 1, 1'b0, 1'b0);
      waitAckLow(ok);
      strobe(8'hA5, 1, 2, 1'b0, 1'b0);
      vectors++; if (O_ACK_N !== 1'b0 || O_ERR !== 2'b10) begin miscompares++; $display("[TB] FAIL rack_pre got %b/%b want 0/10", O_ACK_N, O_ERR); end
      I_RESET = 1'b1;
      @(posedge I_CLK);
      #1;
      vectors++; if (O_ACK_N !== 1'b1 || O_BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL rack_hs got %b/%b want 1/0", O_ACK_N, O_BUSY); end
      vectors++; if (O_LEVEL !== 4'd0 || O_Q_VALID !== 1'b0) begin miscompares++; $display("[TB] FAIL rack_fifo got %0d/%b want 0/0", O_LEVEL, O_Q_VALID); end
      vectors++; if (O_ERR !== 2'b00) begin miscompares++; $display("[TB] FAIL rack_err got %b want 00", O_ERR); end
      applyReset();
   endtask

   task automatic test_random();
      int pre, ackLow, lowCycles, expPre, ackEdge, lastEdge;
      bit ok;
      logic [7:0] d;
      applyReset();
      randReady = 1'b1;
      for (int iter = 0; iter < 25; iter++) begin
         d = 8'($urandom);
         lowCycles = $urandom_range(1, 6);
         strobe(d, lowCycles, 1, 1'b0, 1'b0);
         waitHandshake(pre, ackLow, ok);
         ackEdge  = (2 + BUSY_HOLD > lowCycles + 2) ? 2 + BUSY_HOLD : lowCycles + 2;
         lastEdge = ((lowCycles > 3) ? lowCycles : 3) - 1;
         expPre   = ackEdge - lastEdge - 1;
         vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL rnd_handshake got timeout want ack pulse"); end
         vectors++; if (pre != expPre) begin miscompares++; $display("[TB] FAIL rnd_hold got %0d want %0d", pre, expPre); end
         vectors++; if (ackLow != ACK_CYCLES) begin miscompares++; $display("[TB] FAIL rnd_ack got %0d want %0d", ackLow, ACK_CYCLES); end
         vectors++; if (O_LEVEL !== 4'(q.size())) begin miscompares++; $display("[TB] FAIL rnd_level got %0d want %0d", O_LEVEL, q.size()); end
         vectors++; if (O_BUSY !== (q.size() == DEPTH)) begin miscompares++; $display("[TB] FAIL rnd_busy got %b want %b", O_BUSY, q.size() == DEPTH); end
         vectors++; if (O_Q_DATA !== ((q.size() > 0) ? q[0] : lastData)) begin miscompares++; $display("[TB] FAIL rnd_head got %h want %h", O_Q_DATA, (q.size() > 0) ? q[0] : lastData); end
         vectors++; if (O_ERR !== expErr) begin miscompares++; $display("[TB] FAIL rnd_err got %b want %b", O_ERR, expErr); end
      end
      randReady = 1'b0;
      I_Q_READY = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_capture();
      test_overflow_drain();
      test_busy_error();
      test_full_push_pop();
      test_held_low_reset();
      test_reset_in_ack();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
